// File: rtl/alu_pkg.sv
// Shared constants and types for the bit-serial ALU sequencer and its decoder.
package alu_pkg;

   localparam logic [3:0] ALUOP_AND = 4'b0000;
   localparam logic [3:0] ALUOP_OR  = 4'b0001;
   localparam logic [3:0] ALUOP_ADD = 4'b0010;
   localparam logic [3:0] ALUOP_SUB = 4'b0110;
   localparam logic [3:0] ALUOP_SLT = 4'b0111;
   localparam logic [3:0] ALUOP_NOR = 4'b1100;

   localparam logic [1:0] OP_AND  = 2'b00;
   localparam logic [1:0] OP_OR   = 2'b01;
   localparam logic [1:0] OP_SUM  = 2'b10;
   localparam logic [1:0] OP_LESS = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_RUN    = 2'b01,
      ST_LESS   = 2'b10,
      ST_FINISH = 2'b11
   } state_t;

   typedef struct packed {
      logic       ainv;
      logic       binv;
      logic [1:0] op;
      logic       cin0;
      logic       is_arith;
      logic       is_slt;
   } dec_t;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational ALUop decode into slice control fields; unknown codes behave as AND.
module alu_op_decode
   import alu_pkg::*;
(
   input  logic [3:0] alu_op,
   output dec_t       dec
);

   always_comb begin
      dec = '{ainv: 1'b0, binv: 1'b0, op: OP_AND, cin0: 1'b0, is_arith: 1'b0, is_slt: 1'b0};
      case (alu_op)
         ALUOP_OR:  dec.op = OP_OR;
         ALUOP_ADD: begin
            dec.op       = OP_SUM;
            dec.is_arith = 1'b1;
         end
         ALUOP_SUB, ALUOP_SLT: begin
            dec.binv     = 1'b1;
            dec.op       = OP_SUM;
            dec.cin0     = 1'b1;
            dec.is_arith = 1'b1;
            dec.is_slt   = (alu_op == ALUOP_SLT);
         end
         ALUOP_NOR: begin
            dec.ainv = 1'b1;
            dec.binv = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: drives an external 1-bit slice LSB first and
// assembles the WIDTH-bit result and flags.
//
// state     | meaning
// ST_IDLE   | waiting for Start
// ST_RUN    | one operand bit per cycle through the slice
// ST_LESS   | SLT only: route the set bit through the slice Less input
// ST_FINISH | Done pulse; Start here chains directly into ST_RUN
module alu_serial_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             Clock,
   input  logic             Resetn,
   input  logic             Start,
   input  logic [3:0]       ALUop,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic             Overflow,
   output logic             CarryOut,
   output logic             s_A,
   output logic             s_B,
   output logic             s_Ainvert,
   output logic             s_Binvert,
   output logic             s_Carry_in,
   output logic             s_Less,
   output logic [1:0]       s_Operation,
   input  logic             s_Result,
   input  logic             s_Carry_out
);

   localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_t           state_q, state_d;
   dec_t             dec_q, dec_d, dec_w;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d, zero_q, zero_d;
   logic             ovf_q, ovf_d, cout_q, cout_d, set_q, set_d;
   logic             ovf_w;

   alu_op_decode u_dec (
      .alu_op (ALUop),
      .dec    (dec_w)
   );

   // Slice drive depends only on registers, so the slice round trip never loops back here.
   always_comb begin
      s_A         = 1'b0;
      s_B         = 1'b0;
      s_Ainvert   = 1'b0;
      s_Binvert   = 1'b0;
      s_Carry_in  = 1'b0;
      s_Less      = 1'b0;
      s_Operation = OP_AND;
      case (state_q)
         ST_RUN: begin
            s_A         = a_q[0];
            s_B         = b_q[0];
            s_Ainvert   = dec_q.ainv;
            s_Binvert   = dec_q.binv;
            s_Carry_in  = carry_q;
            s_Operation = dec_q.op;
         end
         ST_LESS: begin
            s_Less      = set_q;
            s_Operation = OP_LESS;
         end
         default: ;
      endcase
   end

   assign ovf_w = carry_q ^ s_Carry_out;

   always_comb begin
      state_d  = state_q;
      dec_d    = dec_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      ovf_d    = ovf_q;
      cout_d   = cout_q;
      set_d    = set_q;
      case (state_q)
         ST_IDLE, ST_FINISH: begin
            if (Start) begin
               state_d  = ST_RUN;
               dec_d    = dec_w;
               a_d      = A;
               b_d      = B;
               result_d = '0;
               cnt_d    = '0;
               carry_d  = dec_w.cin0;
               zero_d   = 1'b0;
               ovf_d    = 1'b0;
               cout_d   = 1'b0;
               set_d    = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_RUN: begin
            result_d = {s_Result, result_q[WIDTH-1:1]};
            carry_d  = s_Carry_out;
            a_d      = a_q >> 1;
            b_d      = b_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               if (dec_q.is_arith) begin
                  ovf_d  = ovf_w;
                  cout_d = s_Carry_out;
                  set_d  = s_Result ^ ovf_w;
               end
               zero_d  = (result_d == '0);
               state_d = dec_q.is_slt ? ST_LESS : ST_FINISH;
            end
         end
         ST_LESS: begin
            result_d = {{(WIDTH-1){1'b0}}, s_Result};
            zero_d   = ~s_Result;
            state_d  = ST_FINISH;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state_q  <= ST_IDLE;
         dec_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
         cout_q   <= 1'b0;
         set_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         dec_q    <= dec_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
         cout_q   <= cout_d;
         set_q    <= set_d;
      end
   end

   assign Busy     = (state_q == ST_RUN) || (state_q == ST_LESS);
   assign Done     = (state_q == ST_FINISH);
   assign Result   = result_q;
   assign Zero     = zero_q;
   assign Overflow = ovf_q;
   assign CarryOut = cout_q;

endmodule

// File: tb/tb_alu_serial_seq.sv
// Directed bench for alu_serial_seq with a behavioural 1-bit ALU slice on the s_* ports.
module tb_alu_serial_seq;

   logic        Clock = 1'b0;
   logic        Resetn = 1'b0;
   logic        Start = 1'b0;
   logic [3:0]  ALUop = 4'b0000;
   logic [31:0] A = '0;
   logic [31:0] B = '0;
   logic        Busy, Done, Zero, Overflow, CarryOut;
   logic [31:0] Result;
   logic        s_A, s_B, s_Ainvert, s_Binvert, s_Carry_in, s_Less;
   logic [1:0]  s_Operation;
   logic        s_Result, s_Carry_out;

   int errors = 0;
   int checks = 0;
   int lat;

   always #5 Clock = ~Clock;

   alu_serial_seq #(.WIDTH(32)) dut (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .Start       (Start),
      .ALUop       (ALUop),
      .A           (A),
      .B           (B),
      .Busy        (Busy),
      .Done        (Done),
      .Result      (Result),
      .Zero        (Zero),
      .Overflow    (Overflow),
      .CarryOut    (CarryOut),
      .s_A         (s_A),
      .s_B         (s_B),
      .s_Ainvert   (s_Ainvert),
      .s_Binvert   (s_Binvert),
      .s_Carry_in  (s_Carry_in),
      .s_Less      (s_Less),
      .s_Operation (s_Operation),
      .s_Result    (s_Result),
      .s_Carry_out (s_Carry_out)
   );

   // Behavioural 1-bit slice
   logic sa, sb, ssum;
   assign sa          = s_A ^ s_Ainvert;
   assign sb          = s_B ^ s_Binvert;
   assign ssum        = sa ^ sb ^ s_Carry_in;
   assign s_Carry_out = (sa & sb) | (sa & s_Carry_in) | (sb & s_Carry_in);
   assign s_Result    = (s_Operation == 2'b00) ? (sa & sb) :
                        (s_Operation == 2'b01) ? (sa | sb) :
                        (s_Operation == 2'b10) ? ssum : s_Less;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge Clock);
      ALUop = op;
      A     = a;
      B     = b;
      Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
   endtask

   // Cycles counted from the accepting edge; the cycle right after it is 1.
   task automatic wait_done(output int n);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge Clock);
         n++;
         if (Done) break;
      end
   endtask

   initial begin
      repeat (2) @(negedge Clock);
      check("reset_flags", {19'b0, Busy, Done, Zero, Overflow, CarryOut, s_A, s_B,
                            s_Ainvert, s_Binvert, s_Carry_in, s_Less, s_Operation}, 32'h0);
      check("reset_result", Result, 32'h0);
      Resetn = 1'b1;

      launch(4'b0010, 32'd5, 32'd3);
      wait_done(lat);
      check("add_latency", 32'(lat), 32'd33);
      check("add_result", Result, 32'h0000_0008);
      check("add_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h0);
      check("add_busy_done", {30'b0, Busy, Done}, 32'h1);
      repeat (3) @(negedge Clock);
      check("add_hold", {31'b0, Done} ^ Result, 32'h0000_0008);

      launch(4'b0110, 32'd3, 32'd5);
      wait_done(lat);
      check("sub_result", Result, 32'hFFFF_FFFE);
      check("sub_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h0);

      launch(4'b0110, 32'h1234, 32'h1234);
      wait_done(lat);
      check("sub_eq_result", Result, 32'h0);
      check("sub_eq_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h6);

      launch(4'b0010, 32'h7FFF_FFFF, 32'd1);
      wait_done(lat);
      check("add_ovf_result", Result, 32'h8000_0000);
      check("add_ovf_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h1);

      launch(4'b0110, 32'h8000_0000, 32'd1);
      wait_done(lat);
      check("sub_ovf_result", Result, 32'h7FFF_FFFF);
      check("sub_ovf_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h3);

      launch(4'b0111, 32'hFFFF_FFFF, 32'd1);
      wait_done(lat);
      check("slt_latency", 32'(lat), 32'd34);
      check("slt_result", Result, 32'h1);
      check("slt_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h2);

      launch(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000);
      wait_done(lat);
      check("slt_ovf_result", Result, 32'h0);
      check("slt_ovf_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h5);

      launch(4'b1100, 32'h0, 32'h0);
      wait_done(lat);
      check("nor_result", Result, 32'hFFFF_FFFF);
      check("nor_flags", {29'b0, Zero, CarryOut, Overflow}, 32'h0);

      launch(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_done(lat);
      check("and_result", Result, 32'hF000_F000);

      launch(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_done(lat);
      check("or_result", Result, 32'hFFF0_FFF0);

      launch(4'b1111, 32'hF0F0_F0F0, 32'hFF00_FF00);
      wait_done(lat);
      check("default_as_and", Result, 32'hF000_F000);

      // Start pulsed mid-operation must be ignored
      launch(4'b0010, 32'd5, 32'd3);
      lat = 0;
      for (int c = 1; c <= 50; c++) begin
         @(negedge Clock);
         lat = c;
         if (c == 10) begin
            Start = 1'b1;
            ALUop = 4'b0110;
            A     = 32'h0000_FFFF;
            B     = 32'd1;
         end
         if (c == 11) Start = 1'b0;
         if (Done) break;
      end
      check("busy_start_latency", 32'(lat), 32'd33);
      check("busy_start_result", Result, 32'h0000_0008);

      // Asynchronous reset mid-operation
      launch(4'b0010, 32'h7FFF_FFFF, 32'd1);
      repeat (15) @(negedge Clock);
      Resetn = 1'b0;
      #1;
      check("midreset_flags", {19'b0, Busy, Done, Zero, Overflow, CarryOut, s_A, s_B,
                               s_Ainvert, s_Binvert, s_Carry_in, s_Less, s_Operation}, 32'h0);
      check("midreset_result", Result, 32'h0);
      @(negedge Clock);
      Resetn = 1'b1;

      // Back-to-back: Start held during FINISH
      launch(4'b0010, 32'd5, 32'd3);
      wait_done(lat);
      check("b2b_first_result", Result, 32'h0000_0008);
      ALUop = 4'b0001;
      A     = 32'hF0F0_F0F0;
      B     = 32'hFF00_FF00;
      Start = 1'b1;
      @(posedge Clock);
      #1 Start = 1'b0;
      check("b2b_busy", {31'b0, Busy}, 32'h1);
      wait_done(lat);
      check("b2b_latency", 32'(lat), 32'd33);
      check("b2b_result", Result, 32'hFFF0_FFF0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
